// File: rtl/cipher_readout_tx.sv
// -----------------------------------------------------------------------------
// cipher_readout_tx
//   Dumps the 8 bytes of an upstream cipher store over a UART-style serial
//   line (1 start bit, 8 data bits LSB first, 1 stop bit). Each byte is fetched
//   from the store in a single FETCH cycle and then shifted out.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..1023)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   one-cycle request to dump all 8 bytes (IDLE only)
//   view_sel in   1 = encrypted view, 0 = decrypted view; sampled with start
//   abort    in   terminate the dump in progress
//   rd_data  in   [7:0] byte from store for rd_idx/view
//   rd_idx   out  [2:0] byte index presented to the store
//   view     out  view select presented to the store
//   tx       out  serial line, idle high
//   busy     out  high while a dump is in progress
//   done     out  one-cycle pulse after the last stop bit
// -----------------------------------------------------------------------------
module cipher_readout_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       view_sel,
   input  logic       abort,
   input  logic [7:0] rd_data,
   output logic [2:0] rd_idx,
   output logic       view,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START_BIT,
      DATA,
      STOP_BIT
   } state_t;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [2:0]       bit_q,    bit_d;
   logic [7:0]       sh_q,     sh_d;
   logic [2:0]       rd_idx_q, rd_idx_d;
   logic             view_q,   view_d;
   logic             tx_q,     tx_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic             bit_end;

   assign bit_end = (cnt_q == CNT_MAX);

   // All outputs are computed for the next cycle and registered, so tx/busy/
   // done change exactly on the cycle the state does.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      rd_idx_d = rd_idx_q;
      view_d   = view_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // done_q marks the cycle the previous dump finished; a start there
            // is dropped so back-to-back dumps always have an idle gap.
            if (start && !done_q) begin
               view_d   = view_sel;
               rd_idx_d = 3'd0;
               busy_d   = 1'b1;
               state_d  = FETCH;
            end
         end

         FETCH: begin
            sh_d    = rd_data;
            cnt_d   = '0;
            tx_d    = 1'b0;
            state_d = START_BIT;
         end

         START_BIT: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = sh_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP_BIT;
               end else begin
                  // Shift so the next bit is always at sh_q[0]; its value is
                  // sh_q[1] of the current register.
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  tx_d  = sh_q[1];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STOP_BIT: begin
            if (bit_end) begin
               cnt_d = '0;
               if (rd_idx_q == 3'd7) begin
                  // Index holds at 7 after the last byte.
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + 3'd1;
                  state_d  = FETCH;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Abort overrides whatever the active state decided; IDLE is unaffected.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = 3'd0;
         tx_d    = 1'b1;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= 3'd0;
         sh_q     <= 8'd0;
         rd_idx_q <= 3'd0;
         view_q   <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         rd_idx_q <= rd_idx_d;
         view_q   <= view_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign rd_idx = rd_idx_q;
   assign view   = view_q;
   assign tx     = tx_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cipher_readout_tx.sv
// -----------------------------------------------------------------------------
// tb_cipher_readout_tx
//   Directed stimulus for cipher_readout_tx with CLKS_PER_BIT=4. Expected bytes
//   are pushed into a queue when a dump is launched; an independent UART
//   receiver on tx decodes frames and compares each against the queue head.
// -----------------------------------------------------------------------------
module tb_cipher_readout_tx;

   localparam int CPB       = 4;
   localparam int BYTE_CYC  = 1 + 10 * CPB;   // 41
   localparam int DUMP_CYC  = 8 * BYTE_CYC;   // 328

   logic       clk = 1'b0;
   logic       rst, start, view_sel, abort;
   logic [7:0] rd_data;
   logic [2:0] rd_idx;
   logic       view, tx, busy, done;
   logic       store_mode;   // 0: constant 0xA5, 1: index ^ view

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];

   cipher_readout_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .view_sel (view_sel),
      .abort    (abort),
      .rd_data  (rd_data),
      .rd_idx   (rd_idx),
      .view     (view),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Model cipher store.
   assign rd_data = store_mode ? ({5'b0, rd_idx} ^ {7'b0, view}) : 8'hA5;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump(input logic mode, input logic vs, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(mode ? (8'(i) ^ {7'b0, vs}) : 8'hA5);
   endtask

   // Pulse start, leave the bench just after the accepting edge.
   task automatic launch(input logic vs);
      view_sel = vs;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Runs until done or busy drops. cyc counts edges since the first busy
   // cycle; an optional extra start / abort is applied at given counts.
   task automatic run(input logic exp_view, input int restart_at, input int abort_at,
                      output int cyc);
      int bad;
      bad = 0;
      cyc = 0;
      while (cyc < 2000) begin
         if (done || !busy) break;
         if (view !== exp_view) bad++;
         if (cyc == restart_at) begin
            start    = 1'b1;
            view_sel = ~exp_view;
         end
         if (cyc == abort_at) abort = 1'b1;
         tick();
         start = 1'b0;
         abort = 1'b0;
         cyc++;
      end
      if (cyc >= 2000) begin
         n_checks++;
         n_errors++;
         $display("FAIL run_timeout: got %0d cycles required < 2000", cyc);
      end
      chk("view_stable", bad, 0);
   endtask

   // ---------------- receiver / scoreboard monitor ----------------
   logic       rx_act  = 1'b0;
   logic       tx_prev = 1'b1;
   int         rx_cnt  = 0;
   logic [7:0] rx_byte = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx_prev && !tx) begin
            rx_act  = 1'b1;
            rx_cnt  = 0;
            rx_byte = 8'h00;
         end
      end else begin
         rx_cnt++;
         if (!busy) begin
            rx_act = 1'b0;   // frame cut short by abort/reset
         end else if (rx_cnt == CPB / 2) begin
            chk("start_bit", {31'b0, tx}, 32'd0);
         end else if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB
                      && ((rx_cnt - CPB - CPB / 2) % CPB) == 0) begin
            rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
         end else if (rx_cnt == 9 * CPB + CPB / 2) begin
            chk("stop_bit", {31'b0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got %0h required none", rx_byte);
            end else begin
               chk("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
            end
            rx_act = 1'b0;
         end
      end
      tx_prev = tx;
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int dbad;
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      view_sel   = 1'b0;
      store_mode = 1'b0;
      tick();
      tick();
      chk("rst_tx",     {31'b0, tx},     32'd1);
      chk("rst_busy",   {31'b0, busy},   32'd0);
      chk("rst_done",   {31'b0, done},   32'd0);
      chk("rst_rd_idx", {29'b0, rd_idx}, 32'd0);
      chk("rst_view",   {31'b0, view},   32'd0);
      rst = 1'b0;
      tick();

      // 1: constant 0xA5 store, full dump timing
      store_mode = 1'b0;
      push_dump(1'b0, 1'b0, 8);
      launch(1'b0);
      chk("t1_busy",   {31'b0, busy},   32'd1);
      chk("t1_rd_idx", {29'b0, rd_idx}, 32'd0);
      chk("t1_tx",     {31'b0, tx},     32'd1);
      run(1'b0, -1, -1, cyc);
      chk("t1_cycles", cyc, DUMP_CYC);
      chk("t1_done",   {31'b0, done},   32'd1);
      chk("t1_busy_end", {31'b0, busy}, 32'd0);
      chk("t1_idx_end",  {29'b0, rd_idx}, 32'd7);
      tick();
      chk("t1_done_pulse", {31'b0, done}, 32'd0);

      // 2: index ^ view store, encrypted view
      store_mode = 1'b1;
      push_dump(1'b1, 1'b1, 8);
      launch(1'b1);
      chk("t2_view", {31'b0, view}, 32'd1);
      run(1'b1, -1, -1, cyc);
      chk("t2_cycles", cyc, DUMP_CYC);
      chk("t2_view_end", {31'b0, view}, 32'd1);
      tick();

      // 3: start pulsed again during byte 3 is ignored
      push_dump(1'b1, 1'b0, 8);
      launch(1'b0);
      run(1'b0, 3 * BYTE_CYC + 10, -1, cyc);
      chk("t3_cycles", cyc, DUMP_CYC);
      chk("t3_done",   {31'b0, done}, 32'd1);
      tick();

      // 4: abort in DATA bit 4 of byte 2, then restart with abort+start
      push_dump(1'b1, 1'b0, 2);
      launch(1'b0);
      run(1'b0, -1, 2 * BYTE_CYC + 5 + 4 * 4 + 1, cyc);
      chk("t4_abort_cyc", cyc, 2 * BYTE_CYC + 5 + 4 * 4 + 2);
      chk("t4_busy", {31'b0, busy}, 32'd0);
      chk("t4_tx",   {31'b0, tx},   32'd1);
      dbad = 0;
      for (int i = 0; i < 5; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) dbad++;
         tick();
      end
      chk("t4_no_done", dbad, 0);
      push_dump(1'b1, 1'b0, 8);
      abort = 1'b1;
      launch(1'b0);
      abort = 1'b0;
      chk("t4_restart_busy", {31'b0, busy},   32'd1);
      chk("t4_restart_idx",  {29'b0, rd_idx}, 32'd0);
      run(1'b0, -1, -1, cyc);
      chk("t4_cycles", cyc, DUMP_CYC);
      tick();

      // 5: reset during byte 1 start bit; reset beats start
      push_dump(1'b1, 1'b1, 1);
      launch(1'b1);
      repeat (BYTE_CYC + 2) tick();
      chk("t5_pre_tx",  {31'b0, tx},     32'd0);
      chk("t5_pre_idx", {29'b0, rd_idx}, 32'd1);
      rst = 1'b1;
      tick();
      chk("t5_tx",     {31'b0, tx},     32'd1);
      chk("t5_busy",   {31'b0, busy},   32'd0);
      chk("t5_rd_idx", {29'b0, rd_idx}, 32'd0);
      chk("t5_view",   {31'b0, view},   32'd0);
      start = 1'b1;
      tick();
      chk("t5_rst_start_busy", {31'b0, busy}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("t5_idle_busy", {31'b0, busy}, 32'd0);
      chk("t5_idle_tx",   {31'b0, tx},   32'd1);

      // 6: start in the done cycle ignored, next cycle accepted
      store_mode = 1'b0;
      push_dump(1'b0, 1'b0, 8);
      launch(1'b0);
      run(1'b0, -1, -1, cyc);
      chk("t6_cycles", cyc, DUMP_CYC);
      chk("t6_done",   {31'b0, done}, 32'd1);
      store_mode = 1'b1;
      push_dump(1'b1, 1'b1, 8);
      view_sel = 1'b1;
      start    = 1'b1;
      tick();
      chk("t6_ignored_busy", {31'b0, busy}, 32'd0);
      chk("t6_ignored_done", {31'b0, done}, 32'd0);
      tick();
      start = 1'b0;
      chk("t6_accept_busy", {31'b0, busy}, 32'd1);
      chk("t6_accept_view", {31'b0, view}, 32'd1);
      run(1'b1, -1, -1, cyc);
      chk("t6_cycles2", cyc, DUMP_CYC);

      repeat (5) tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
